// File: rtl/m_lsu_bus_if.sv
// Handshake bundle between the M pipeline stage, the load/store unit and the
// data bus. The slave modport is the LSU's view. The master modport is the
// environment's view: the pipeline side plus the bus responder.
interface m_lsu_bus_if;
  // Pipeline side
  logic        M_req;
  logic        M_we;
  logic [2:0]  M_LSop;
  logic [31:0] M_addr;
  logic [31:0] M_wdata;
  logic [31:0] M_rdata;
  logic        M_done;
  logic        M_stall;
  logic        M_adel;
  logic        M_ades;
  logic        M_buserr;
  // Data bus side
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport slave (
    input  M_req, M_we, M_LSop, M_addr, M_wdata, bus_ready, bus_rdata,
    output M_rdata, M_done, M_stall, M_adel, M_ades, M_buserr,
           bus_req, bus_we, bus_addr, bus_byteen, bus_wdata
  );

  modport master (
    output M_req, M_we, M_LSop, M_addr, M_wdata, bus_ready, bus_rdata,
    input  M_rdata, M_done, M_stall, M_adel, M_ades, M_buserr,
           bus_req, bus_we, bus_addr, bus_byteen, bus_wdata
  );
endinterface

// File: rtl/m_lsu_bus.sv
// M-stage load/store unit. Captures one request, runs a single bus access
// (or skips it on misalignment), extends load data, and reports completion
// with a one-cycle M_done pulse. Bus outputs and M_* results are gated by the
// FSM state, so the captured data registers need no reset.
module m_lsu_bus #(
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  m_lsu_bus_if.slave     lsu
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adel_q, adel_d;
  logic             ades_q, ades_d;
  logic             buserr_q, buserr_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             req_mis;
  logic             timeout_hit;

  // Reserved encodings 101..111 fall through to word handling.
  function automatic logic op_is_half(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010);
  endfunction

  function automatic logic op_is_byte(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b100);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    if (op_is_half(op)) return a[0];
    if (op_is_byte(op)) return 1'b0;
    return a != 2'b00;
  endfunction

  function automatic logic [3:0] pack_byteen(input logic [2:0] op, input logic [1:0] a);
    if (op_is_half(op)) return a[1] ? 4'b1100 : 4'b0011;
    if (op_is_byte(op)) return 4'b0001 << a;
    return 4'b1111;
  endfunction

  // Store data is replicated across lanes so the byte enables pick the slot.
  function automatic logic [31:0] pack_wdata(input logic [2:0] op, input logic [31:0] d);
    if (op_is_half(op)) return {2{d[15:0]}};
    if (op_is_byte(op)) return {4{d[7:0]}};
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                               input logic [1:0]  a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    case (op)
      3'b001:  return {16'h0000, h};
      3'b010:  return {{16{h[15]}}, h};
      3'b011:  return {24'h000000, b};
      3'b100:  return {{24{b[7]}}, b};
      default: return d;
    endcase
  endfunction

  assign req_mis     = misaligned(lsu.M_LSop, lsu.M_addr[1:0]);
  assign timeout_hit = (cnt_q == CNT_LAST);

  // Control state register; async reset drops bus_req in the same instant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adel_q   <= adel_d;
      ades_q   <= ades_d;
      buserr_q <= buserr_d;
    end
  end

  // Captured request and load result; only observed while the FSM qualifies them.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    op_q    <= op_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  // Next-state logic: IDLE -> BUS -> DONE -> IDLE, misaligned skips BUS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (lsu.M_req) state_d = req_mis ? S_DONE : S_BUS;
      end
      S_BUS: begin
        if (lsu.bus_ready || timeout_hit) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request capture, completion flags and load data for the DONE cycle.
  always_comb begin
    addr_d   = addr_q;
    we_d     = we_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    adel_d   = 1'b0;
    ades_d   = 1'b0;
    buserr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdata_d = '0;
        if (lsu.M_req) begin
          addr_d  = lsu.M_addr;
          we_d    = lsu.M_we;
          op_d    = lsu.M_LSop;
          wdata_d = lsu.M_wdata;
          adel_d  = req_mis & ~lsu.M_we;
          ades_d  = req_mis &  lsu.M_we;
        end
      end
      S_BUS: begin
        if (lsu.bus_ready) begin
          rdata_d = we_q ? 32'h0 : load_extract(op_q, addr_q[1:0], lsu.bus_rdata);
        end else if (timeout_hit) begin
          rdata_d  = '0;
          buserr_d = 1'b1;
        end
      end
      S_DONE: begin
        rdata_d = '0;
      end
      default: begin
        rdata_d = '0;
      end
    endcase
    if (state_q == S_DONE) begin
      adel_d   = 1'b0;
      ades_d   = 1'b0;
      buserr_d = 1'b0;
    end
  end

  // Outputs decoded from state; bus fields come straight from the captured request.
  always_comb begin
    logic busy;
    logic done;
    busy           = (state_q == S_BUS);
    done           = (state_q == S_DONE);
    lsu.bus_req    = busy;
    lsu.bus_we     = busy & we_q;
    lsu.bus_addr   = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    lsu.bus_byteen = (busy && we_q) ? pack_byteen(op_q, addr_q[1:0]) : 4'b0000;
    lsu.bus_wdata  = (busy && we_q) ? pack_wdata(op_q, wdata_q) : 32'h0;
    lsu.M_done     = done;
    lsu.M_rdata    = done ? rdata_q : 32'h0;
    lsu.M_adel     = done & adel_q;
    lsu.M_ades     = done & ades_q;
    lsu.M_buserr   = done & buserr_q;
    lsu.M_stall    = lsu.M_req & ~done;
  end

endmodule

// File: tb/tb_m_lsu_bus.sv
// Directed bench for m_lsu_bus: a table of load/store vectors with
// hand-computed bus and result values, plus short sequences for reset in BUS,
// ready outside BUS and back-to-back requests.
module tb_m_lsu_bus;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  m_lsu_bus_if ifc ();

  m_lsu_bus #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .lsu   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          bcyc;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] rd;
    logic        adel;
    logic        ades;
    logic        berr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic we, logic [2:0] op, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int delay, int bcyc, logic [3:0] be,
                              logic [31:0] bwd, logic [31:0] rd,
                              logic adel, logic ades, logic berr);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.delay = delay; v.bcyc = bcyc; v.be = be; v.bwd = bwd; v.rd = rd;
    v.adel = adel; v.ades = ades; v.berr = berr;
    return v;
  endfunction

  task automatic idle_inputs();
    ifc.M_req = 1'b0; ifc.M_we = 1'b0; ifc.M_LSop = 3'b000;
    ifc.M_addr = 32'h0; ifc.M_wdata = 32'h0;
    ifc.bus_ready = 1'b0; ifc.bus_rdata = 32'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  n;
    int  bcnt;
    bit  done;
    logic [31:0] exp_baddr;
    exp_baddr = {v.addr[31:2], 2'b00};
    @(posedge clk); #1;
    ifc.M_req = 1'b1; ifc.M_we = v.we; ifc.M_LSop = v.op;
    ifc.M_addr = v.addr; ifc.M_wdata = v.wdata; ifc.bus_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d stall_idle", idx), ifc.M_stall, 1'b1);
    chk($sformatf("v%0d done_idle", idx), ifc.M_done, 1'b0);
    n = 0; bcnt = 0; done = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      if (ifc.bus_req && bcnt == v.delay) begin
        ifc.bus_ready = 1'b1; ifc.bus_rdata = v.rdata;
      end else begin
        ifc.bus_ready = 1'b0; ifc.bus_rdata = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      if (ifc.bus_req) begin
        chk($sformatf("v%0d bus_addr", idx), ifc.bus_addr, exp_baddr);
        chk($sformatf("v%0d bus_we", idx), ifc.bus_we, v.we);
        chk($sformatf("v%0d bus_byteen", idx), ifc.bus_byteen, v.be);
        if (v.we) chk($sformatf("v%0d bus_wdata", idx), ifc.bus_wdata, v.bwd);
        chk($sformatf("v%0d stall_bus", idx), ifc.M_stall, 1'b1);
        bcnt++;
      end
      if (ifc.M_done) begin
        done = 1;
        chk($sformatf("v%0d rdata", idx), ifc.M_rdata, v.rd);
        chk($sformatf("v%0d adel", idx), ifc.M_adel, v.adel);
        chk($sformatf("v%0d ades", idx), ifc.M_ades, v.ades);
        chk($sformatf("v%0d buserr", idx), ifc.M_buserr, v.berr);
        chk($sformatf("v%0d stall_done", idx), ifc.M_stall, 1'b0);
        chk($sformatf("v%0d bus_req_done", idx), ifc.bus_req, 1'b0);
      end
      n++;
    end
    chk($sformatf("v%0d completed", idx), done, 1'b1);
    chk($sformatf("v%0d bus_cycles", idx), bcnt, v.bcyc);
    @(posedge clk); #1;
    ifc.M_req = 1'b0; ifc.bus_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", idx), ifc.M_done, 1'b0);
    chk($sformatf("v%0d rdata_clear", idx), ifc.M_rdata, 32'h0);
    chk($sformatf("v%0d bus_idle", idx), ifc.bus_req, 1'b0);
  endtask

  initial begin
    idle_inputs();
    // we op addr wdata rdata delay bcyc be bwd rd adel ades berr
    vecs.push_back(mk(0, 3'b000, 32'h1004, 0, 32'hDEADBEEF, 2, 3, 4'h0, 0, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 32'h2003, 0, 32'h80FF1234, 0, 1, 4'h0, 0, 32'hFFFFFF80, 0, 0, 0));
    vecs.push_back(mk(0, 3'b011, 32'h2003, 0, 32'h80FF1234, 1, 2, 4'h0, 0, 32'h00000080, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h2002, 0, 32'h80FF1234, 0, 1, 4'h0, 0, 32'hFFFF80FF, 0, 0, 0));
    vecs.push_back(mk(0, 3'b001, 32'h2002, 0, 32'h80FF1234, 0, 1, 4'h0, 0, 32'h000080FF, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h2000, 0, 32'h80FF1234, 0, 1, 4'h0, 0, 32'h00001234, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 32'h2002, 0, 32'h80FF1234, 0, 1, 4'h0, 0, 32'hFFFFFFFF, 0, 0, 0));
    vecs.push_back(mk(0, 3'b011, 32'h2000, 0, 32'h80FF1234, 0, 1, 4'h0, 0, 32'h00000034, 0, 0, 0));
    vecs.push_back(mk(1, 3'b011, 32'h0011, 32'h000000AB, 32'h5555AAAA, 1, 2, 4'b0010, 32'hABABABAB, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h0012, 32'h00001234, 32'h5555AAAA, 0, 1, 4'b1100, 32'h12341234, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h0020, 32'hCAFEF00D, 32'h5555AAAA, 0, 1, 4'b1111, 32'hCAFEF00D, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h1000, 32'hFFFF5678, 32'h0, 0, 1, 4'b0011, 32'h56785678, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b100, 32'h0013, 32'h0000007F, 32'h0, 0, 1, 4'b1000, 32'h7F7F7F7F, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 32'h1002, 0, 32'h0, 0, 0, 4'h0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h1001, 32'h1234, 32'h0, 0, 0, 4'h0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 3'b000, 32'h1003, 32'h1234, 32'h0, 0, 0, 4'h0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b010, 32'h2001, 0, 32'h0, 0, 0, 4'h0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 3'b101, 32'h3000, 0, 32'h12345678, 0, 1, 4'h0, 0, 32'h12345678, 0, 0, 0));
    vecs.push_back(mk(0, 3'b111, 32'h3002, 0, 32'h0, 0, 0, 4'h0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 3'b000, 32'h4000, 0, 32'h0, 99, 4, 4'h0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b000, 32'h4004, 0, 32'hA5A5A5A5, 3, 4, 4'h0, 0, 32'hA5A5A5A5, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h4008, 32'h11223344, 32'h0, 99, 4, 4'b1111, 32'h11223344, 0, 0, 0, 1));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst bus_req", ifc.bus_req, 1'b0);
    chk("rst bus_addr", ifc.bus_addr, 32'h0);
    chk("rst bus_byteen", ifc.bus_byteen, 4'h0);
    chk("rst M_done", ifc.M_done, 1'b0);
    chk("rst M_rdata", ifc.M_rdata, 32'h0);
    chk("rst M_stall", ifc.M_stall, 1'b0);
    chk("rst flags", {ifc.M_adel, ifc.M_ades, ifc.M_buserr}, 3'b000);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // bus_ready outside BUS is ignored
    @(posedge clk); #1;
    ifc.bus_ready = 1'b1; ifc.bus_rdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_ready done", ifc.M_done, 1'b0);
      chk("stray_ready bus_req", ifc.bus_req, 1'b0);
    end
    @(posedge clk); #1;
    ifc.bus_ready = 1'b0;

    // Reset asserted while in BUS drops bus_req at once and yields no M_done
    ifc.M_req = 1'b1; ifc.M_we = 1'b0; ifc.M_LSop = 3'b000; ifc.M_addr = 32'h5000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbus bus_req_before", ifc.bus_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rstbus bus_req_now", ifc.bus_req, 1'b0);
    chk("rstbus done_now", ifc.M_done, 1'b0);
    ifc.M_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstbus no_done", ifc.M_done, 1'b0);
      chk("rstbus no_req", ifc.bus_req, 1'b0);
    end

    // Recovery after reset
    run_vec(100, vecs[0]);

    // Back-to-back: M_req held past DONE restarts one cycle later from IDLE
    @(posedge clk); #1;
    ifc.M_req = 1'b1; ifc.M_we = 1'b0; ifc.M_LSop = 3'b000; ifc.M_addr = 32'h6000;
    @(posedge clk); #1;
    ifc.bus_ready = 1'b1; ifc.bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("b2b first_bus", ifc.bus_req, 1'b1);
    @(posedge clk); #1;
    ifc.bus_ready = 1'b0;
    @(negedge clk);
    chk("b2b first_done", ifc.M_done, 1'b1);
    chk("b2b first_rdata", ifc.M_rdata, 32'h0BADF00D);
    @(posedge clk); #1;
    ifc.M_addr = 32'h6004;
    @(negedge clk);
    chk("b2b gap_req", ifc.bus_req, 1'b0);
    chk("b2b gap_done", ifc.M_done, 1'b0);
    chk("b2b gap_stall", ifc.M_stall, 1'b1);
    @(posedge clk); #1;
    ifc.bus_ready = 1'b1; ifc.bus_rdata = 32'hFEEDFACE;
    @(negedge clk);
    chk("b2b second_bus", ifc.bus_req, 1'b1);
    chk("b2b second_addr", ifc.bus_addr, 32'h6004);
    @(posedge clk); #1;
    ifc.bus_ready = 1'b0;
    @(negedge clk);
    chk("b2b second_done", ifc.M_done, 1'b1);
    chk("b2b second_rdata", ifc.M_rdata, 32'hFEEDFACE);
    @(posedge clk); #1;
    ifc.M_req = 1'b0;
    @(negedge clk);
    chk("b2b end_done", ifc.M_done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
